throw_ctrl: RTL and testbench

- Sequencer for the bowling power meter.
- While the player aims, it sweeps the power level 0..4 back and forth at a fixed tick rate.
- A throw-button press freezes and latches the level, which is then offered to the ball/lane logic over a valid/ready handshake.
- After the handoff it waits for the ball to finish rolling before the next aim is allowed.
- Sits between the board switches/keys and the ball-physics block; drives the power-meter LEDs through pow_lvl.

---
 rtl/throw_ctrl.sv | 136 +++++++++++++
 tb/tb_throw_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/throw_ctrl.sv
// Bowling power-meter sequencer: sweeps a bouncing power level while aiming,
// latches it on a throw-button edge and offers it over valid/ready.
module throw_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned MAX_LVL  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       throw_btn,
  input  logic       ball_ready,
  input  logic       ball_done,
  output logic [2:0] pow_lvl,
  output logic       throw_valid,
  output logic [2:0] throw_power,
  output logic [1:0] state
);

  localparam int unsigned CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       LVL_MAX  = 3'(MAX_LVL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SWEEP = 2'b01,
    S_HOLD  = 2'b10,
    S_WAIT  = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_pow,   w_pow_nxt;
  logic [2:0]       r_power, w_power_nxt;
  logic             r_dir,   w_dir_nxt;   // 0 = counting up, 1 = counting down
  logic             r_valid, w_valid_nxt;
  logic             r_btn_prev;
  logic             w_throw_edge;
  logic             w_tick;

  assign w_throw_edge = throw_btn & ~r_btn_prev;
  assign w_tick       = (r_cnt == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pow      <= '0;
      r_power    <= '0;
      r_dir      <= 1'b0;
      r_valid    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pow      <= w_pow_nxt;
      r_power    <= w_power_nxt;
      r_dir      <= w_dir_nxt;
      r_valid    <= w_valid_nxt;
      r_btn_prev <= throw_btn;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pow_nxt   = r_pow;
    w_power_nxt = r_power;
    w_dir_nxt   = r_dir;
    w_valid_nxt = r_valid;

    unique case (r_state)
      S_IDLE: begin
        w_pow_nxt = '0;
        if (start) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
          w_dir_nxt   = 1'b0;
        end
      end

      S_SWEEP: begin
        if (w_throw_edge) begin
          // A throw on a tick cycle wins; the pre-tick level is latched
          w_power_nxt = r_pow;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            if (!r_dir) begin
              if (r_pow < LVL_MAX) begin
                w_pow_nxt = r_pow + 3'd1;
                if (r_pow + 3'd1 == LVL_MAX) w_dir_nxt = 1'b1;
              end else begin
                w_pow_nxt = r_pow - 3'd1;
                w_dir_nxt = 1'b1;
              end
            end else begin
              if (r_pow > 3'd0) begin
                w_pow_nxt = r_pow - 3'd1;
                if (r_pow == 3'd1) w_dir_nxt = 1'b0;
              end else begin
                w_pow_nxt = r_pow + 3'd1;
                w_dir_nxt = 1'b0;
              end
            end
          end
        end
      end

      S_HOLD: begin
        if (r_valid && ball_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ball_done) begin
          w_state_nxt = S_IDLE;
          w_pow_nxt   = '0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pow_lvl     = r_pow;
  assign throw_valid = r_valid;
  assign throw_power = r_power;
  assign state       = r_state;

endmodule

// File: tb/tb_throw_ctrl.sv
// Directed self-checking bench for throw_ctrl (TICK_DIV=4, MAX_LVL=4).
module tb_throw_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       throw_btn;
  logic       ball_ready;
  logic       ball_done;
  logic [2:0] pow_lvl;
  logic       throw_valid;
  logic [2:0] throw_power;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  throw_ctrl #(.TICK_DIV(4), .MAX_LVL(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .throw_btn  (throw_btn),
    .ball_ready (ball_ready),
    .ball_done  (ball_done),
    .pow_lvl    (pow_lvl),
    .throw_valid(throw_valid),
    .throw_power(throw_power),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, input int pl, input int vl, input int pw);
    check({tag, ".state"}, 8'(state), 8'(st));
    check({tag, ".pow_lvl"}, 8'(pow_lvl), 8'(pl));
    check({tag, ".valid"}, 8'(throw_valid), 8'(vl));
    check({tag, ".power"}, 8'(throw_power), 8'(pw));
  endtask

  // Triangle wave 0..4..0 with period 8 ticks
  function automatic int lvl_after(input int ticks);
    int p;
    p = ticks % 8;
    return (p <= 4) ? p : 8 - p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; throw_btn = 1'b0; ball_ready = 1'b0; ball_done = 1'b0;
    step(); step();
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b1;

    // Free sweep: 0,1,2,3,4,3,2,1,0,1,2,3 at one step per 4 cycles
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("sweep_entry", 1, 0, 0, 0);
    for (int j = 1; j <= 44; j++) begin
      step();
      check($sformatf("sweep_pow_%0d", j), 8'(pow_lvl), 8'(lvl_after(j / 4)));
      check($sformatf("sweep_st_%0d", j), 8'(state), 8'd1);
    end

    // Throw at level 3 with ready already high
    throw_btn = 1'b1; ball_ready = 1'b1;
    step();
    check_all("throw3", 2, 3, 1, 3);
    step();
    check_all("xfer3", 3, 3, 0, 3);
    throw_btn = 1'b0; ball_ready = 1'b0;
    start = 1'b1;
    step();
    check("wait_ignores_start", 8'(state), 8'd3);
    start = 1'b0;
    ball_done = 1'b1;
    step();
    ball_done = 1'b0;
    check_all("done3", 0, 0, 0, 3);

    // Backpressure: throw at level 2, ready low for 10 cycles
    start = 1'b1;
    step();
    start = 1'b0;
    ball_done = 1'b1;
    step();
    ball_done = 1'b0;
    check("sweep_ignores_done", 8'(state), 8'd1);
    repeat (7) step();
    check("pre_bp_pow", 8'(pow_lvl), 8'd2);
    throw_btn = 1'b1;
    step();
    check_all("bp_throw", 2, 2, 1, 2);
    for (int i = 0; i < 10; i++) begin
      throw_btn = 1'(i % 2);
      ball_done = (i == 5);
      step();
      check_all($sformatf("bp_hold_%0d", i), 2, 2, 1, 2);
    end
    throw_btn = 1'b0; ball_done = 1'b0; ball_ready = 1'b1;
    step();
    check_all("bp_xfer", 3, 2, 0, 2);
    ball_ready = 1'b0; ball_done = 1'b1;
    step();
    ball_done = 1'b0;
    check_all("bp_done", 0, 0, 0, 2);

    // Collision: throw on the same cycle as the 2->3 tick
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    check("col_pre_pow", 8'(pow_lvl), 8'd2);
    throw_btn = 1'b1;
    step();
    check_all("col_throw", 2, 2, 1, 2);
    ball_ready = 1'b1;
    step();
    ball_ready = 1'b0; ball_done = 1'b1;
    step();
    ball_done = 1'b0;
    check("col_done", 8'(state), 8'd0);

    // Button held through SWEEP entry: no throw until release and re-press
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("held_st_%0d", i), 8'(state), 8'd1);
    end
    throw_btn = 1'b0;
    step();
    check_all("held_release", 1, 1, 0, 2);
    throw_btn = 1'b1;
    step();
    check_all("held_repress", 2, 1, 1, 1);
    ball_ready = 1'b1;
    step();
    ball_ready = 1'b0; ball_done = 1'b1; throw_btn = 1'b0;
    step();
    ball_done = 1'b0;
    check("held_done", 8'(state), 8'd0);

    // Level-0 throw, then async reset while HOLD has valid high
    start = 1'b1;
    step();
    start = 1'b0;
    throw_btn = 1'b1;
    step();
    check_all("throw0", 2, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    throw_btn = 1'b0;
    step();
    #3;
    reset = 1'b1;
    step();
    check_all("post_rst", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
